// File: rtl/vga_ctrl.sv
// 640x480@60 Hz VGA timing generator: pixel/line counters, sync decodes, and one-cycle-early
// coordinate requests to vga_pic, whose registered pixel data is gated onto the RGB565 output.
module vga_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 40,
  parameter int unsigned H_LEFT   = 8,
  parameter int unsigned H_VALID  = 640,
  parameter int unsigned H_RIGHT  = 8,
  parameter int unsigned H_FRONT  = 8,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 25,
  parameter int unsigned V_TOP    = 8,
  parameter int unsigned V_VALID  = 480,
  parameter int unsigned V_BOTTOM = 8,
  parameter int unsigned V_FRONT  = 2,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_ACT = H_SYNC + H_BACK + H_LEFT;
  localparam int unsigned V_ACT = V_SYNC + V_BACK + V_TOP;

  // An inconsistent segment/total geometry keeps the display blanked.
  localparam bit GeomOk = (H_ACT + H_VALID + H_RIGHT + H_FRONT == H_TOTAL) &&
                          (V_ACT + V_VALID + V_BOTTOM + V_FRONT == V_TOTAL);

  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncEnd = 10'(H_SYNC);
  localparam logic [9:0] VSyncEnd = 10'(V_SYNC);
  localparam logic [9:0] HActBeg  = 10'(H_ACT);
  localparam logic [9:0] HActEnd  = 10'(H_ACT + H_VALID - 1);
  localparam logic [9:0] HReqBeg  = 10'(H_ACT - 1);
  localparam logic [9:0] HReqEnd  = 10'(H_ACT + H_VALID - 2);
  localparam logic [9:0] VActBeg  = 10'(V_ACT);
  localparam logic [9:0] VActEnd  = 10'(V_ACT + V_VALID - 1);

  logic [9:0] r_cnt_h;
  logic [9:0] r_cnt_v;
  logic       r_frame_start;
  logic [7:0] r_frame_cnt;

  logic [9:0] w_cnt_h_d;
  logic [9:0] w_cnt_v_d;
  logic       w_h_end;
  logic       w_frame_end;
  logic       w_h_act;
  logic       w_h_req;
  logic       w_v_act;
  logic       w_pix_req;

  always_comb begin
    w_h_end     = (r_cnt_h == HLast);
    w_frame_end = w_h_end && (r_cnt_v == VLast);
    w_cnt_h_d   = w_h_end ? 10'd0 : r_cnt_h + 10'd1;
    w_cnt_v_d   = r_cnt_v;
    if (w_h_end) begin
      w_cnt_v_d = (r_cnt_v == VLast) ? 10'd0 : r_cnt_v + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_h       <= 10'd0;
      r_cnt_v       <= 10'd0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_cnt_h       <= w_cnt_h_d;
      r_cnt_v       <= w_cnt_v_d;
      r_frame_start <= w_frame_end;
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // The request window leads the display window by one column to cover vga_pic's register.
  always_comb begin
    w_v_act   = GeomOk && (r_cnt_v >= VActBeg) && (r_cnt_v <= VActEnd);
    w_h_act   = (r_cnt_h >= HActBeg) && (r_cnt_h <= HActEnd);
    w_h_req   = (r_cnt_h >= HReqBeg) && (r_cnt_h <= HReqEnd);
    w_pix_req = w_h_req && w_v_act;
    hsync     = (r_cnt_h < HSyncEnd);
    vsync     = (r_cnt_v < VSyncEnd);
    rgb_valid = w_h_act && w_v_act;
    pix_x     = w_pix_req ? (r_cnt_h - HReqBeg) : 10'h3FF;
    pix_y     = w_pix_req ? (r_cnt_v - VActBeg) : 10'h3FF;
    rgb       = rgb_valid ? pix_data : 16'h0000;
  end

  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: full-size instance for line timing and the first active line, and a
// shrunken-geometry instance for frame wrap, mid-frame reset and the 255->0 frame count wrap.
module tb_vga_ctrl;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        valid;
    logic [15:0] rgb;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    int hs; int hb; int hl; int hv; int ht;
    int vs; int vb; int vtop; int vv; int vt;
  } geom_t;

  typedef struct {
    int          n;
    logic        fen;
    logic [15:0] fval;
    obs_t        exp;
    string       name;
  } vec_t;

  geom_t ga = '{hs:96, hb:40, hl:8, hv:640, ht:800, vs:2, vb:25, vtop:8, vv:480, vt:525};
  geom_t gb = '{hs:3, hb:2, hl:1, hv:8, ht:16, vs:2, vb:1, vtop:1, vv:4, vt:10};

  logic        clk = 1'b0;
  logic        rst_a_n = 1'b0;
  logic        rst_b_n = 1'b0;
  logic        force_a_en = 1'b1;
  logic        force_b_en = 1'b1;
  logic [15:0] force_a_val = 16'hFFFF;
  logic [15:0] force_b_val = 16'hFFFF;
  logic [15:0] pic_a_q = 16'h0;
  logic [15:0] pic_b_q = 16'h0;
  logic [15:0] pix_data_a;
  logic [15:0] pix_data_b;

  logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic        hsync_a, vsync_a, rgb_valid_a, frame_start_a;
  logic        hsync_b, vsync_b, rgb_valid_b, frame_start_b;
  logic [15:0] rgb_a, rgb_b;
  logic [7:0]  frame_cnt_a, frame_cnt_b;

  int n_a = 0;
  int n_b = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_ctrl u_dut_a (
    .vga_clk     (clk),
    .sys_rst_n   (rst_a_n),
    .pix_data    (pix_data_a),
    .pix_x       (pix_x_a),
    .pix_y       (pix_y_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .rgb_valid   (rgb_valid_a),
    .rgb         (rgb_a),
    .frame_start (frame_start_a),
    .frame_cnt   (frame_cnt_a)
  );

  vga_ctrl #(
    .H_SYNC(3), .H_BACK(2), .H_LEFT(1), .H_VALID(8), .H_RIGHT(1), .H_FRONT(1), .H_TOTAL(16),
    .V_SYNC(2), .V_BACK(1), .V_TOP(1), .V_VALID(4), .V_BOTTOM(1), .V_FRONT(1), .V_TOTAL(10)
  ) u_dut_b (
    .vga_clk     (clk),
    .sys_rst_n   (rst_b_n),
    .pix_data    (pix_data_b),
    .pix_x       (pix_x_b),
    .pix_y       (pix_y_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .rgb_valid   (rgb_valid_b),
    .rgb         (rgb_b),
    .frame_start (frame_start_b),
    .frame_cnt   (frame_cnt_b)
  );

  function automatic logic [15:0] pic(logic [9:0] x, logic [9:0] y);
    if (x == 10'd0 && y == 10'd0) return 16'hF800;
    return {y[5:0], x} ^ 16'h5A3C;
  endfunction

  // Stand-in for vga_pic: one registered stage, random garbage outside any request.
  always @(posedge clk) begin
    pic_a_q <= (pix_x_a != 10'h3FF) ? pic(pix_x_a, pix_y_a) : 16'($urandom);
    pic_b_q <= (pix_x_b != 10'h3FF) ? pic(pix_x_b, pix_y_b) : 16'($urandom);
  end
  assign pix_data_a = force_a_en ? force_a_val : pic_a_q;
  assign pix_data_b = force_b_en ? force_b_val : pic_b_q;

  // Clock edges since reset release define the expected screen position.
  always @(posedge clk or negedge rst_a_n) n_a <= !rst_a_n ? 0 : n_a + 1;
  always @(posedge clk or negedge rst_b_n) n_b <= !rst_b_n ? 0 : n_b + 1;

  function automatic obs_t mk(logic hs, logic vs, logic valid, logic [15:0] rgb, logic [9:0] px,
                              logic [9:0] py, logic fs, logic [7:0] fc);
    return {hs, vs, valid, rgb, px, py, fs, fc};
  endfunction

  function automatic obs_t obs_a();
    return mk(hsync_a, vsync_a, rgb_valid_a, rgb_a, pix_x_a, pix_y_a, frame_start_a, frame_cnt_a);
  endfunction

  function automatic obs_t obs_b();
    return mk(hsync_b, vsync_b, rgb_valid_b, rgb_b, pix_x_b, pix_y_b, frame_start_b, frame_cnt_b);
  endfunction

  function automatic obs_t model(int n, geom_t g, logic fen, logic [15:0] fval);
    int   h, v, hact, vact, frame;
    logic vin, valid, req;
    obs_t o;
    frame = g.ht * g.vt;
    h     = n % g.ht;
    v     = (n / g.ht) % g.vt;
    hact  = g.hs + g.hb + g.hl;
    vact  = g.vs + g.vb + g.vtop;
    vin   = (v >= vact) && (v < vact + g.vv);
    valid = vin && (h >= hact) && (h < hact + g.hv);
    req   = vin && (h >= hact - 1) && (h < hact + g.hv - 1);
    o.hs    = (h < g.hs);
    o.vs    = (v < g.vs);
    o.valid = valid;
    o.px    = req ? 10'(h - hact + 1) : 10'h3FF;
    o.py    = req ? 10'(v - vact) : 10'h3FF;
    o.rgb   = !valid ? 16'h0 : (fen ? fval : pic(10'(h - hact), 10'(v - vact)));
    o.fs    = (n > 0) && (n % frame == 0);
    o.fc    = 8'((n / frame) % 256);
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (hs,vs,valid,rgb,px,py,fs,fc)", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(bit use_b, int target);
    int guard = 0;
    while (((use_b ? n_b : n_a) < target) && guard < 70000) begin
      tick();
      guard++;
    end
    if (guard >= 70000) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_timeout: reached %0d required %0d", use_b ? n_b : n_a, target);
    end
  endtask

  // Random-time scoreboard against the position model.
  always @(negedge clk) begin
    if (rst_a_n && $urandom_range(0, 7) == 0)
      check("scan_a", obs_a(), model(n_a, ga, force_a_en, force_a_val));
    if (rst_b_n && $urandom_range(0, 3) == 0)
      check("scan_b", obs_b(), model(n_b, gb, force_b_en, force_b_val));
  end

  int   hs_hi_a = 0;
  int   px_busy_a = 0;
  logic hs_prev_a = 1'b1;
  int   rise_a[$];
  always @(negedge clk) begin
    if (rst_a_n && n_a <= 1600) begin
      if (n_a < 1600 && hsync_a) hs_hi_a <= hs_hi_a + 1;
      if (n_a > 0 && hsync_a && !hs_prev_a) rise_a.push_back(n_a);
      if (pix_x_a != 10'h3FF) px_busy_a <= px_busy_a + 1;
      hs_prev_a <= hsync_a;
    end
  end

  logic mon_b = 1'b0;
  int   fs_early_b = 0;
  always @(negedge clk) begin
    if (mon_b && rst_b_n && n_b < 160 && frame_start_b) fs_early_b <= fs_early_b + 1;
  end

  initial begin
    vec_t vec[$];
    obs_t rst_obs;
    int   cnt;
    int   hi;
    logic prev;
    int   rises[$];

    rst_obs = mk(1, 1, 0, 16'h0, 10'h3FF, 10'h3FF, 0, 8'd0);
    vec.push_back('{1,     1'b1, 16'hFFFF, rst_obs, "blank_start"});
    vec.push_back('{95,    1'b1, 16'hFFFF, rst_obs, "hsync_last"});
    vec.push_back('{96,    1'b1, 16'hFFFF, mk(0, 1, 0, 16'h0, 10'h3FF, 10'h3FF, 0, 0), "hsync_fall"});
    vec.push_back('{799,   1'b1, 16'hFFFF, mk(0, 1, 0, 16'h0, 10'h3FF, 10'h3FF, 0, 0), "line_end"});
    vec.push_back('{800,   1'b1, 16'hFFFF, rst_obs, "line1_start"});
    vec.push_back('{1600,  1'b1, 16'hFFFF, mk(1, 0, 0, 16'h0, 10'h3FF, 10'h3FF, 0, 0), "vsync_fall"});
    vec.push_back('{28143, 1'b0, 16'h0000, mk(0, 0, 0, 16'h0, 10'd0, 10'd0, 0, 0), "first_req"});
    vec.push_back('{28144, 1'b0, 16'h0000, mk(0, 0, 1, 16'hF800, 10'd1, 10'd0, 0, 0), "first_pix"});
    vec.push_back('{28782, 1'b1, 16'h1234, mk(0, 0, 1, 16'h1234, 10'd639, 10'd0, 0, 0), "last_req"});
    vec.push_back('{28783, 1'b1, 16'hBEEF,
                    mk(0, 0, 1, 16'hBEEF, 10'h3FF, 10'h3FF, 0, 0), "valid_no_req"});
    vec.push_back('{28784, 1'b1, 16'hFFFF, mk(0, 0, 0, 16'h0, 10'h3FF, 10'h3FF, 0, 0), "blank_after"});
    vec.push_back('{28943, 1'b0, 16'h0000, mk(0, 0, 0, 16'h0, 10'd0, 10'd1, 0, 0), "line36_req"});
    vec.push_back('{28944, 1'b0, 16'h0000, mk(0, 0, 1, 16'h5E3C, 10'd1, 10'd1, 0, 0), "line36_pix"});

    repeat (3) tick();
    #2;
    check("reset_a", obs_a(), rst_obs);
    check("reset_b", obs_b(), rst_obs);

    tick();
    rst_a_n = 1'b1;
    foreach (vec[i]) begin
      wait_n(1'b0, vec[i].n);
      force_a_en  = vec[i].fen;
      force_a_val = vec[i].fval;
      #2;
      check(vec[i].name, obs_a(), vec[i].exp);
    end
    check_int("hsync_high_2lines", hs_hi_a, 192);
    check_int("hsync_first_rise", (rise_a.size() > 0) ? rise_a[0] : -1, 800);
    check_int("hsync_period", (rise_a.size() == 2) ? rise_a[1] - rise_a[0] : -1, 800);
    check_int("pix_x_idle_2lines", px_busy_a, 0);

    // Small geometry: 16 clocks/line, 10 lines/frame, active h 6..13, v 4..7.
    tick();
    rst_b_n    = 1'b1;
    force_b_en = 1'b0;
    wait_n(1'b1, 409);
    #2;
    check("pre_reset_b", obs_b(), model(n_b, gb, force_b_en, force_b_val));
    check_int("frame_cnt_before_reset", frame_cnt_b, 2);
    rst_b_n     = 1'b0;
    force_b_en  = 1'b1;
    force_b_val = 16'hFFFF;
    #1;
    check("mid_reset_async", obs_b(), rst_obs);
    repeat (2) tick();
    #2;
    check("reset_held_b", obs_b(), rst_obs);
    tick();
    rst_b_n    = 1'b1;
    force_b_en = 1'b0;
    mon_b      = 1'b1;
    wait_n(1'b1, 1);
    #2;
    check("restart_b", obs_b(), rst_obs);

    wait_n(1'b1, 124);
    force_b_en  = 1'b1;
    force_b_val = 16'h1357;
    #2;
    check("last_pixel_req_b", obs_b(), mk(0, 0, 1, 16'h1357, 10'd7, 10'd3, 0, 0));
    force_b_val = 16'hFFFF;
    cnt = 0;
    for (int k = 128; k <= 143; k++) begin
      wait_n(1'b1, k);
      #2;
      if (rgb_valid_b || rgb_b != 16'h0) cnt++;
    end
    check_int("blank_line_after_active", cnt, 0);
    force_b_en = 1'b0;

    wait_n(1'b1, 159);
    #2;
    check("pre_wrap_b", obs_b(), mk(0, 0, 0, 16'h0, 10'h3FF, 10'h3FF, 0, 0));
    wait_n(1'b1, 160);
    #2;
    check("frame_wrap_b", obs_b(), mk(1, 1, 0, 16'h0, 10'h3FF, 10'h3FF, 1, 1));
    wait_n(1'b1, 161);
    #2;
    check("after_wrap_b", obs_b(), mk(1, 1, 0, 16'h0, 10'h3FF, 10'h3FF, 0, 1));
    check_int("no_frame_start_first_frame", fs_early_b, 0);

    prev = vsync_b;
    hi   = 0;
    for (int k = 162; k <= 480; k++) begin
      wait_n(1'b1, k);
      #2;
      if (k >= 320 && k < 480 && vsync_b) hi++;
      if (vsync_b && !prev) rises.push_back(k);
      prev = vsync_b;
    end
    check_int("vsync_high_per_frame", hi, 32);
    check_int("vsync_first_rise", (rises.size() > 0) ? rises[0] : -1, 320);
    check_int("vsync_period", (rises.size() == 2) ? rises[1] - rises[0] : -1, 160);

    // Long randomized run up to the 8-bit frame counter wrap.
    repeat (40958 - n_b) begin
      tick();
      force_b_en  = ($urandom_range(0, 3) == 0);
      force_b_val = 16'($urandom);
    end
    wait_n(1'b1, 40959);
    #2;
    check("frame_cnt_255", obs_b(), mk(0, 0, 0, 16'h0, 10'h3FF, 10'h3FF, 0, 8'd255));
    wait_n(1'b1, 40960);
    #2;
    check("frame_cnt_wrap", obs_b(), mk(1, 1, 0, 16'h0, 10'h3FF, 10'h3FF, 1, 8'd0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
